// File: rtl/hop_pipe.sv
// hop_pipe: pipelined fixed-point photon hop (pos += step*u) with saturating kill and valid/ready flow.
// Define HOP_SAT_COUNT_EN to add the sat_count port counting photons killed inside this block.
module hop_pipe #(
    parameter int BIT_WIDTH = 32,
    parameter int FRAC_BITS = 31,
    parameter int LATENCY   = 2,
    parameter int TAG_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] x_in,
    input  logic [BIT_WIDTH-1:0] y_in,
    input  logic [BIT_WIDTH-1:0] z_in,
    input  logic [BIT_WIDTH-1:0] ux_in,
    input  logic [BIT_WIDTH-1:0] uy_in,
    input  logic [BIT_WIDTH-1:0] uz_in,
    input  logic [BIT_WIDTH-1:0] sr_in,
    input  logic [BIT_WIDTH-1:0] sz_in,
    input  logic                 dead_in,
    input  logic                 hit_in,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] x_out,
    output logic [BIT_WIDTH-1:0] y_out,
    output logic [BIT_WIDTH-1:0] z_out,
    output logic                 dead_out,
    output logic                 hit_out,
    output logic [TAG_WIDTH-1:0] tag_out
`ifdef HOP_SAT_COUNT_EN
    ,
    output logic [15:0]          sat_count
`endif
);

    localparam int W = BIT_WIDTH;
    localparam logic [BIT_WIDTH-1:0] POS_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic [BIT_WIDTH-1:0] NEG_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    localparam logic [BIT_WIDTH-1:0] ZERO    = {BIT_WIDTH{1'b0}};

    function automatic logic [BIT_WIDTH-1:0] hop_delta(input logic [BIT_WIDTH-1:0] s,
                                                       input logic [BIT_WIDTH-1:0] u);
        logic signed [2*BIT_WIDTH-1:0] prod;
        prod = $signed({{BIT_WIDTH{s[BIT_WIDTH-1]}}, s}) * $signed({{BIT_WIDTH{u[BIT_WIDTH-1]}}, u});
        return BIT_WIDTH'(prod >>> FRAC_BITS);
    endfunction

    function automatic logic [BIT_WIDTH:0] hop_sum(input logic [BIT_WIDTH-1:0] pos,
                                                   input logic [BIT_WIDTH-1:0] delta);
        return {pos[BIT_WIDTH-1], pos} + {delta[BIT_WIDTH-1], delta};
    endfunction

    function automatic logic sum_ovf(input logic [BIT_WIDTH:0] sum);
        return sum[BIT_WIDTH] ^ sum[BIT_WIDTH-1];
    endfunction

    logic                 advance_s;

    logic                 s1_valid_d, s1_valid_q;
    logic [W-1:0]         s1_x_d, s1_x_q, s1_y_d, s1_y_q, s1_z_d, s1_z_q;
    logic [W-1:0]         s1_dx_d, s1_dx_q, s1_dy_d, s1_dy_q, s1_dz_d, s1_dz_q;
    logic                 s1_dead_d, s1_dead_q, s1_hit_d, s1_hit_q;
    logic [TAG_WIDTH-1:0] s1_tag_d, s1_tag_q;

    logic [W:0]           sum_x_s, sum_y_s, sum_z_s;
    logic [W-1:0]         x_new_s, y_new_s, z_new_s;
    logic                 kill_x_s, kill_y_s, kill_z_s, kill_any_s, dead_new_s;

    logic                 stg_valid_d [2:LATENCY];
    logic                 stg_valid_q [2:LATENCY];
    logic [W-1:0]         stg_x_d     [2:LATENCY];
    logic [W-1:0]         stg_x_q     [2:LATENCY];
    logic [W-1:0]         stg_y_d     [2:LATENCY];
    logic [W-1:0]         stg_y_q     [2:LATENCY];
    logic [W-1:0]         stg_z_d     [2:LATENCY];
    logic [W-1:0]         stg_z_q     [2:LATENCY];
    logic                 stg_dead_d  [2:LATENCY];
    logic                 stg_dead_q  [2:LATENCY];
    logic                 stg_hit_d   [2:LATENCY];
    logic                 stg_hit_q   [2:LATENCY];
    logic [TAG_WIDTH-1:0] stg_tag_d   [2:LATENCY];
    logic [TAG_WIDTH-1:0] stg_tag_q   [2:LATENCY];

    // The whole pipe moves as one unit: it advances whenever the output slot is free or being drained.
    assign advance_s = ~stg_valid_q[LATENCY] | out_ready;
    assign in_ready  = advance_s;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_z_d     = s1_z_q;
        s1_dx_d    = s1_dx_q;
        s1_dy_d    = s1_dy_q;
        s1_dz_d    = s1_dz_q;
        s1_dead_d  = s1_dead_q;
        s1_hit_d   = s1_hit_q;
        s1_tag_d   = s1_tag_q;
        if (advance_s) begin
            s1_valid_d = in_valid;
            s1_x_d     = x_in;
            s1_y_d     = y_in;
            s1_z_d     = z_in;
            s1_dx_d    = hop_delta(sr_in, ux_in);
            s1_dy_d    = hop_delta(sr_in, uy_in);
            s1_dz_d    = hop_delta(sz_in, uz_in);
            s1_dead_d  = dead_in;
            s1_hit_d   = hit_in;
            s1_tag_d   = tag_in;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 add: x/y saturate toward the overflow sign; z always saturates high, clamps negatives to 0.
    always_comb begin
        sum_x_s  = hop_sum(s1_x_q, s1_dx_q);
        sum_y_s  = hop_sum(s1_y_q, s1_dy_q);
        sum_z_s  = hop_sum(s1_z_q, s1_dz_q);
        kill_x_s = sum_ovf(sum_x_s);
        kill_y_s = sum_ovf(sum_y_s);
        if (kill_x_s) begin
            x_new_s = sum_x_s[W] ? NEG_MIN : POS_MAX;
        end else begin
            x_new_s = sum_x_s[W-1:0];
        end
        if (kill_y_s) begin
            y_new_s = sum_y_s[W] ? NEG_MIN : POS_MAX;
        end else begin
            y_new_s = sum_y_s[W-1:0];
        end
        if (s1_hit_q) begin
            z_new_s  = s1_z_q;
            kill_z_s = 1'b0;
        end else if (sum_ovf(sum_z_s)) begin
            z_new_s  = POS_MAX;
            kill_z_s = 1'b1;
        end else if (sum_z_s[W-1]) begin
            z_new_s  = ZERO;
            kill_z_s = 1'b1;
        end else begin
            z_new_s  = sum_z_s[W-1:0];
            kill_z_s = 1'b0;
        end
        kill_any_s = kill_x_s | kill_y_s | kill_z_s;
        dead_new_s = s1_dead_q | kill_any_s;
    end

    always_comb begin
        stg_valid_d = stg_valid_q;
        stg_x_d     = stg_x_q;
        stg_y_d     = stg_y_q;
        stg_z_d     = stg_z_q;
        stg_dead_d  = stg_dead_q;
        stg_hit_d   = stg_hit_q;
        stg_tag_d   = stg_tag_q;
        if (advance_s) begin
            stg_valid_d[2] = s1_valid_q;
            stg_x_d[2]     = x_new_s;
            stg_y_d[2]     = y_new_s;
            stg_z_d[2]     = z_new_s;
            stg_dead_d[2]  = dead_new_s;
            stg_hit_d[2]   = s1_hit_q;
            stg_tag_d[2]   = s1_tag_q;
            for (int k = 3; k <= LATENCY; k++) begin
                stg_valid_d[k] = stg_valid_q[k-1];
                stg_x_d[k]     = stg_x_q[k-1];
                stg_y_d[k]     = stg_y_q[k-1];
                stg_z_d[k]     = stg_z_q[k-1];
                stg_dead_d[k]  = stg_dead_q[k-1];
                stg_hit_d[k]   = stg_hit_q[k-1];
                stg_tag_d[k]   = stg_tag_q[k-1];
            end
        end else begin
            stg_valid_d = stg_valid_q;
        end
    end

    // Reset empties every stage; idle slots look like dead photons at the origin.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= ZERO;
            s1_y_q     <= ZERO;
            s1_z_q     <= ZERO;
            s1_dx_q    <= ZERO;
            s1_dy_q    <= ZERO;
            s1_dz_q    <= ZERO;
            s1_dead_q  <= 1'b1;
            s1_hit_q   <= 1'b0;
            s1_tag_q   <= {TAG_WIDTH{1'b0}};
            for (int k = 2; k <= LATENCY; k++) begin
                stg_valid_q[k] <= 1'b0;
                stg_x_q[k]     <= ZERO;
                stg_y_q[k]     <= ZERO;
                stg_z_q[k]     <= ZERO;
                stg_dead_q[k]  <= 1'b1;
                stg_hit_q[k]   <= 1'b0;
                stg_tag_q[k]   <= {TAG_WIDTH{1'b0}};
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_z_q      <= s1_z_d;
            s1_dx_q     <= s1_dx_d;
            s1_dy_q     <= s1_dy_d;
            s1_dz_q     <= s1_dz_d;
            s1_dead_q   <= s1_dead_d;
            s1_hit_q    <= s1_hit_d;
            s1_tag_q    <= s1_tag_d;
            stg_valid_q <= stg_valid_d;
            stg_x_q     <= stg_x_d;
            stg_y_q     <= stg_y_d;
            stg_z_q     <= stg_z_d;
            stg_dead_q  <= stg_dead_d;
            stg_hit_q   <= stg_hit_d;
            stg_tag_q   <= stg_tag_d;
        end
    end

    assign out_valid = stg_valid_q[LATENCY];
    assign x_out     = stg_x_q[LATENCY];
    assign y_out     = stg_y_q[LATENCY];
    assign z_out     = stg_z_q[LATENCY];
    assign dead_out  = stg_dead_q[LATENCY];
    assign hit_out   = stg_hit_q[LATENCY];
    assign tag_out   = stg_tag_q[LATENCY];

`ifdef HOP_SAT_COUNT_EN
    logic        stg_kill_d [2:LATENCY];
    logic        stg_kill_q [2:LATENCY];
    logic [15:0] sat_count_d, sat_count_q;

    // Only photons that arrived alive and were killed here are counted.
    always_comb begin
        stg_kill_d = stg_kill_q;
        if (advance_s) begin
            stg_kill_d[2] = kill_any_s & ~s1_dead_q;
            for (int k = 3; k <= LATENCY; k++) begin
                stg_kill_d[k] = stg_kill_q[k-1];
            end
        end else begin
            stg_kill_d = stg_kill_q;
        end
        if (stg_valid_q[LATENCY] && out_ready && stg_kill_q[LATENCY] && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
        end else begin
            sat_count_d = sat_count_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 2; k <= LATENCY; k++) begin
                stg_kill_q[k] <= 1'b0;
            end
            sat_count_q <= 16'd0;
        end else begin
            stg_kill_q  <= stg_kill_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_hop_pipe.sv
// Randomized self-checking bench for hop_pipe (default LATENCY=2 instance plus a LATENCY=5 instance).
`timescale 1ns/1ps
module tb_hop_pipe;

    logic        clock;
    logic        reset, in_valid, out_ready, in_ready, out_valid;
    logic [31:0] x_in, y_in, z_in, ux_in, uy_in, uz_in, sr_in, sz_in;
    logic        dead_in, hit_in;
    logic [7:0]  tag_in;
    logic [31:0] x_out, y_out, z_out;
    logic        dead_out, hit_out;
    logic [7:0]  tag_out;
    logic        reset5, in_valid5, out_ready5, in_ready5, out_valid5;
    logic [31:0] x_out5, y_out5, z_out5;
    logic        dead_out5, hit_out5;
    logic [7:0]  tag_out5;
`ifdef HOP_SAT_COUNT_EN
    logic [15:0] sat_count, sat_count5;
`endif

    typedef struct {
        logic [31:0] x, y, z;
        logic        dead, hit, kill;
        logic [7:0]  tag;
    } exp_t;

    exp_t        sb[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          n_out = 0;
    int          n_in = 0;
    logic [15:0] exp_sat = 16'd0;
    logic        acc;

    hop_pipe dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .ux_in(ux_in), .uy_in(uy_in), .uz_in(uz_in),
        .sr_in(sr_in), .sz_in(sz_in), .dead_in(dead_in), .hit_in(hit_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .dead_out(dead_out), .hit_out(hit_out), .tag_out(tag_out)
`ifdef HOP_SAT_COUNT_EN
        , .sat_count(sat_count)
`endif
    );

    hop_pipe #(.LATENCY(5)) dut5 (
        .clock(clock), .reset(reset5), .in_valid(in_valid5), .in_ready(in_ready5),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .ux_in(ux_in), .uy_in(uy_in), .uz_in(uz_in),
        .sr_in(sr_in), .sz_in(sz_in), .dead_in(dead_in), .hit_in(hit_in), .tag_in(tag_in),
        .out_valid(out_valid5), .out_ready(out_ready5), .x_out(x_out5), .y_out(y_out5), .z_out(z_out5),
        .dead_out(dead_out5), .hit_out(hit_out5), .tag_out(tag_out5)
`ifdef HOP_SAT_COUNT_EN
        , .sat_count(sat_count5)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tg, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tg, obs, exp);
    endtask

    // Reference: real-valued step = floor(s*u / 2^31), then range-checked 64-bit add.
    function automatic longint ref_delta(input logic [31:0] s, input logic [31:0] u);
        longint p;
        p = longint'(int'(s)) * longint'(int'(u));
        return longint'(int'(p >>> 31));
    endfunction

    function automatic logic [32:0] ref_xy(input logic [31:0] pos, input longint d);
        longint sum;
        sum = longint'(int'(pos)) + d;
        if (sum > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
        else if (sum < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        else return {1'b0, sum[31:0]};
    endfunction

    function automatic logic [32:0] ref_z(input logic [31:0] pos, input longint d, input logic hit);
        longint sum;
        sum = longint'(int'(pos)) + d;
        if (hit) return {1'b0, pos};
        else if (sum > 64'sd2147483647 || sum < -64'sd2147483648) return {1'b1, 32'h7FFF_FFFF};
        else if (sum < 64'sd0) return {1'b1, 32'h0000_0000};
        else return {1'b0, sum[31:0]};
    endfunction

    function automatic exp_t ref_hop();
        exp_t        e;
        logic [32:0] rx, ry, rz;
        rx     = ref_xy(x_in, ref_delta(sr_in, ux_in));
        ry     = ref_xy(y_in, ref_delta(sr_in, uy_in));
        rz     = ref_z(z_in, ref_delta(sz_in, uz_in), hit_in);
        e.x    = rx[31:0];
        e.y    = ry[31:0];
        e.z    = rz[31:0];
        e.dead = dead_in | rx[32] | ry[32] | rz[32];
        e.kill = ~dead_in & (rx[32] | ry[32] | rz[32]);
        e.hit  = hit_in;
        e.tag  = tag_in;
        return e;
    endfunction

    task automatic set_photon(input logic [31:0] x, y, z, ux, uy, uz, sr, sz,
                              input logic dead, hit, input logic [7:0] tg);
        x_in = x; y_in = y; z_in = z; ux_in = ux; uy_in = uy; uz_in = uz;
        sr_in = sr; sz_in = sz; dead_in = dead; hit_in = hit; tag_in = tg;
    endtask

    function automatic logic [31:0] rand_pos();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 1000));
            1:       return 32'h7FFF_F000 + 32'($urandom_range(0, 4095));
            2:       return 32'h8000_0000 + 32'($urandom_range(0, 4095));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic rand_photon(input logic [7:0] tg);
        set_photon(rand_pos(), rand_pos(), rand_pos(), 32'($urandom), 32'($urandom), 32'($urandom),
                   ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 5000)) : 32'($urandom),
                   ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 5000)) : 32'($urandom),
                   1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0), tg);
    endtask

    // Called at a falling edge: drive handshakes, score output/input transfers, wait one cycle.
    task automatic drive_cycle(input logic v, input logic rdy, output logic accepted);
        exp_t e;
        in_valid = v;
        out_ready = rdy;
        #1;
        accepted = in_valid & in_ready;
        if (out_valid && !out_ready) check_eq("stall_in_ready", 64'(in_ready), 64'd0);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                n_out++;
                check_eq("x_out", 64'(x_out), 64'(e.x));
                check_eq("y_out", 64'(y_out), 64'(e.y));
                check_eq("z_out", 64'(z_out), 64'(e.z));
                check_eq("dead_out", 64'(dead_out), 64'(e.dead));
                check_eq("hit_out", 64'(hit_out), 64'(e.hit));
                check_eq("tag_out", 64'(tag_out), 64'(e.tag));
                if (e.kill && exp_sat != 16'hFFFF) exp_sat = exp_sat + 16'd1;
            end
        end
        if (accepted) begin
            sb.push_back(ref_hop());
            n_in++;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        exp_sat = 16'd0;
        n_in = 0;
        n_out = 0;
    endtask

    task automatic send_one(input string tg, input logic [31:0] ex_x, input logic [31:0] ex_z,
                            input logic ex_dead);
        logic a;
        drive_cycle(1'b1, 1'b1, a);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (out_valid) break;
            @(negedge clock);
        end
        check_eq({tg, "_valid"}, 64'(out_valid), 64'd1);
        check_eq({tg, "_x"}, 64'(x_out), 64'(ex_x));
        check_eq({tg, "_z"}, 64'(z_out), 64'(ex_z));
        check_eq({tg, "_dead"}, 64'(dead_out), 64'(ex_dead));
        drive_cycle(1'b0, 1'b1, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1);
    end

    initial begin
        int acc_n;
        reset = 1'b1; reset5 = 1'b1; in_valid = 1'b0; in_valid5 = 1'b0;
        out_ready = 1'b1; out_ready5 = 1'b1;
        set_photon(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 8'd0);
        @(negedge clock);
        do_reset();
        reset5 = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_xyz", {x_out, y_out | z_out}, 64'd0);
        check_eq("rst_dead", 64'(dead_out), 64'd1);
        check_eq("rst_hit_tag", 64'({hit_out, tag_out}), 64'd0);
`ifdef HOP_SAT_COUNT_EN
        check_eq("rst_sat_count", 64'(sat_count), 64'd0);
`endif
        @(negedge clock);

        // Basic hop with exact two-cycle latency.
        set_photon(32'd0, 32'd5, 32'd7, 32'h4000_0000, 32'd0, 32'd0, 32'd100, 32'd3, 1'b0, 1'b0, 8'hA1);
        drive_cycle(1'b1, 1'b1, acc);
        check_eq("basic_accept", 64'(acc), 64'd1);
        for (int k = 1; k <= 2; k++) begin
            in_valid = 1'b0;
            out_ready = 1'b1;
            #1;
            check_eq("lat2_valid", 64'(out_valid), 64'(k == 2));
            if (k == 2) begin
                check_eq("basic_x", 64'(x_out), 64'd50);
                check_eq("basic_yz", {y_out, z_out}, {32'd5, 32'd7});
                check_eq("basic_dead", 64'(dead_out), 64'd0);
            end
            drive_cycle(1'b0, 1'b1, acc);
        end

        set_photon(32'h7FFF_FFF0, 32'd0, 32'd7, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd1000, 32'd0, 1'b0, 1'b0, 8'd1);
        send_one("sat_pos", 32'h7FFF_FFFF, 32'd7, 1'b1);
        set_photon(32'h8000_0010, 32'd0, 32'd7, 32'h8000_0001, 32'd0, 32'd0, 32'd1000, 32'd0, 1'b0, 1'b0, 8'd2);
        send_one("sat_neg", 32'h8000_0000, 32'd7, 1'b1);
        set_photon(32'd0, 32'd0, 32'd10, 32'd0, 32'd0, 32'hC000_0000, 32'd0, 32'd100, 1'b0, 1'b0, 8'd3);
        send_one("z_neg", 32'd0, 32'd0, 1'b1);
        set_photon(32'd0, 32'd0, 32'd10, 32'd0, 32'd0, 32'hC000_0000, 32'd0, 32'd100, 1'b0, 1'b1, 8'd4);
        send_one("z_hit", 32'd0, 32'd10, 1'b0);
        set_photon(32'd0, 32'd0, 32'h7FFF_FFF0, 32'd0, 32'd0, 32'h7FFF_FFFF, 32'd0, 32'd1000, 1'b0, 1'b0, 8'd5);
        send_one("z_ovf", 32'd0, 32'h7FFF_FFFF, 1'b1);
        set_photon(32'd20, 32'd0, 32'd10, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 8'd6);
        send_one("dead_in", 32'd20, 32'd10, 1'b1);
`ifdef HOP_SAT_COUNT_EN
        check_eq("sat_count_directed", 64'(sat_count), 64'd4);
`endif

        // Eight-photon stream with the output stalled for cycles 3..6.
        do_reset();
        acc_n = 0;
        for (int c = 0; c < 60 && (acc_n < 8 || sb.size() > 0); c++) begin
            rand_photon(8'(acc_n));
            drive_cycle(1'(acc_n < 8), 1'(!(c >= 3 && c <= 6)), acc);
            if (acc) acc_n++;
        end
        check_eq("stream_accepted", 64'(acc_n), 64'd8);
        check_eq("stream_out", 64'(n_out), 64'd8);
        check_eq("stream_left", 64'(sb.size()), 64'd0);

        // Randomized traffic with random backpressure, then drain.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rand_photon(8'(n_in));
            drive_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), acc);
        end
        for (int c = 0; c < 20 && sb.size() > 0; c++) drive_cycle(1'b0, 1'b1, acc);
        check_eq("rand_left", 64'(sb.size()), 64'd0);
        check_eq("rand_count", 64'(n_out), 64'(n_in));
`ifdef HOP_SAT_COUNT_EN
        check_eq("sat_count_rand", 64'(sat_count), 64'(exp_sat));
`endif

        // LATENCY=5 instance: exact latency, then reset while a photon is one stage from the output.
        set_photon(32'd0, 32'd5, 32'd7, 32'h4000_0000, 32'd0, 32'd0, 32'd100, 32'd3, 1'b0, 1'b0, 8'h55);
        in_valid5 = 1'b1;
        #1;
        check_eq("l5_in_ready", 64'(in_ready5), 64'd1);
        @(negedge clock);
        in_valid5 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            check_eq("lat5_valid", 64'(out_valid5), 64'(k == 5));
            if (k == 5) check_eq("lat5_x_tag", {x_out5, 24'd0, tag_out5}, {32'd50, 32'h55});
            @(negedge clock);
        end
        in_valid5 = 1'b1;
        @(negedge clock);
        in_valid5 = 1'b0;
        repeat (3) @(negedge clock);
        reset5 = 1'b1;
        @(negedge clock);
        #1;
        check_eq("l5_reset_valid", 64'(out_valid5), 64'd0);
        check_eq("l5_reset_dead", 64'(dead_out5), 64'd1);
        reset5 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            #1;
            check_eq("l5_flushed", 64'(out_valid5), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
